// File: rtl/bfs_config_regfile.sv
// BFS configuration register block: bus-visible config, shadow/active threshold
// pairs per channel with busy-deferred commit, start pulse, W1C status and irq.

module bfs_thr_lane #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bus_we_hi,
    input  logic          bus_we_med,
    input  logic [DW-1:0] wr_data,
    input  logic          lse_we,
    input  logic [DW-1:0] lse_hi,
    input  logic [DW-1:0] lse_med,
    input  logic          commit,
    output logic [DW-1:0] sh_hi,
    output logic [DW-1:0] sh_med,
    output logic [DW-1:0] act_hi,
    output logic [DW-1:0] act_med
);
    logic [DW-1:0] sh_hi_q, sh_hi_d, sh_med_q, sh_med_d;
    logic [DW-1:0] act_hi_q, act_hi_d, act_med_q, act_med_d;

    // LSE update wins over both the bus write and the commit for this lane
    always_comb begin
        sh_hi_d   = sh_hi_q;
        sh_med_d  = sh_med_q;
        act_hi_d  = act_hi_q;
        act_med_d = act_med_q;
        if (bus_we_hi)  sh_hi_d  = wr_data;
        if (bus_we_med) sh_med_d = wr_data;
        if (commit) begin
            act_hi_d  = sh_hi_q;
            act_med_d = sh_med_q;
        end
        if (lse_we) begin
            sh_hi_d   = lse_hi;
            sh_med_d  = lse_med;
            act_hi_d  = lse_hi;
            act_med_d = lse_med;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_hi_q   <= '0;
            sh_med_q  <= '0;
            act_hi_q  <= '0;
            act_med_q <= '0;
        end else begin
            sh_hi_q   <= sh_hi_d;
            sh_med_q  <= sh_med_d;
            act_hi_q  <= act_hi_d;
            act_med_q <= act_med_d;
        end
    end

    assign sh_hi   = sh_hi_q;
    assign sh_med  = sh_med_q;
    assign act_hi  = act_hi_q;
    assign act_med = act_med_q;
endmodule

module bfs_config_regfile #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_CH     = 4,
    parameter logic [31:0] ID_VALUE   = 32'hBF50_0002
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    input  logic                         engine_busy,
    input  logic                         engine_done,
    input  logic [NUM_CH-1:0]            lse_we,
    input  logic [NUM_CH*DATA_WIDTH-1:0] lse_high_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] lse_med_in,
    output logic [DATA_WIDTH-1:0]        start_node_address,
    output logic [DATA_WIDTH-1:0]        graph_base_address,
    output logic [NUM_CH*DATA_WIDTH-1:0] high_thr,
    output logic [NUM_CH*DATA_WIDTH-1:0] med_thr,
    output logic                         start_pulse,
    output logic                         irq
);
    localparam int WAW = ADDR_WIDTH - 2;
    localparam logic [WAW-1:0] A_SN = WAW'(1), A_GB = WAW'(2), A_CTRL = WAW'(3), A_STAT = WAW'(4);
    localparam logic [DATA_WIDTH-1:0] ID_W = DATA_WIDTH'(ID_VALUE);

    logic [WAW-1:0] wa, ra;
    assign wa = wr_addr[ADDR_WIDTH-1:2];
    assign ra = rd_addr[ADDR_WIDTH-1:2];

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{wr_addr[1:0], rd_addr[1:0]};

    logic [DATA_WIDTH-1:0] start_node_q, start_node_d, graph_base_q, graph_base_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic rd_valid_q, rd_valid_d, start_pulse_q, start_pulse_d, irq_q, irq_d;
    logic irq_en_q, irq_en_d, done_q, done_d, lock_err_q, lock_err_d;
    logic collide_q, collide_d, commit_pend_q, commit_pend_d;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] sh_hi, sh_med, act_hi, act_med, lse_hi, lse_med;
    logic [NUM_CH-1:0] bus_we_hi, bus_we_med, collide_hit;
    logic commit_go;

    assign lse_hi    = lse_high_in;
    assign lse_med   = lse_med_in;
    assign commit_go = commit_pend_q && !engine_busy;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        logic hit_hi, hit_med;
        assign hit_hi         = wr_en && (wa == WAW'(8 + 2*g));
        assign hit_med        = wr_en && (wa == WAW'(9 + 2*g));
        assign bus_we_hi[g]   = hit_hi  && !lse_we[g];
        assign bus_we_med[g]  = hit_med && !lse_we[g];
        assign collide_hit[g] = (hit_hi || hit_med) && lse_we[g];

        bfs_thr_lane #(.DW(DATA_WIDTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .bus_we_hi (bus_we_hi[g]),
            .bus_we_med(bus_we_med[g]),
            .wr_data   (wr_data),
            .lse_we    (lse_we[g]),
            .lse_hi    (lse_hi[g]),
            .lse_med   (lse_med[g]),
            .commit    (commit_go),
            .sh_hi     (sh_hi[g]),
            .sh_med    (sh_med[g]),
            .act_hi    (act_hi[g]),
            .act_med   (act_med[g])
        );
    end

    logic wr_sn, wr_gb, wr_ctrl, wr_stat, lock_hit, ctrl_ok;
    logic [DATA_WIDTH-1:0] rd_mux;

    always_comb begin
        wr_sn   = wr_en && (wa == A_SN);
        wr_gb   = wr_en && (wa == A_GB);
        wr_ctrl = wr_en && (wa == A_CTRL);
        wr_stat = wr_en && (wa == A_STAT);
        // a START request while busy poisons the whole CONTROL write
        lock_hit = engine_busy && (wr_sn || wr_gb || (wr_ctrl && wr_data[0]));
        ctrl_ok  = wr_ctrl && !(engine_busy && wr_data[0]);

        start_node_d  = (wr_sn && !engine_busy) ? wr_data : start_node_q;
        graph_base_d  = (wr_gb && !engine_busy) ? wr_data : graph_base_q;
        irq_en_d      = ctrl_ok ? wr_data[1] : irq_en_q;
        start_pulse_d = ctrl_ok && wr_data[0];
        commit_pend_d = (commit_pend_q && !commit_go) || (ctrl_ok && wr_data[2]);

        done_d    = (done_q     && !(wr_stat && wr_data[1])) || engine_done;
        lock_err_d = (lock_err_q && !(wr_stat && wr_data[2])) || lock_hit;
        collide_d = (collide_q  && !(wr_stat && wr_data[3])) || (|collide_hit);
        irq_d     = irq_en_d && (done_d || lock_err_d || collide_d);

        rd_mux = '0;
        case (ra)
            WAW'(0): rd_mux = ID_W;
            A_SN:    rd_mux = start_node_q;
            A_GB:    rd_mux = graph_base_q;
            A_CTRL:  rd_mux = DATA_WIDTH'({irq_en_q, 1'b0});
            A_STAT:  rd_mux = DATA_WIDTH'({commit_pend_q, collide_q, lock_err_q, done_q, engine_busy});
            default: rd_mux = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (ra == WAW'(8 + 2*i)) rd_mux = sh_hi[i];
            if (ra == WAW'(9 + 2*i)) rd_mux = sh_med[i];
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_node_q  <= '0;
            graph_base_q  <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            start_pulse_q <= 1'b0;
            irq_q         <= 1'b0;
            irq_en_q      <= 1'b0;
            done_q        <= 1'b0;
            lock_err_q    <= 1'b0;
            collide_q     <= 1'b0;
            commit_pend_q <= 1'b0;
        end else begin
            start_node_q  <= start_node_d;
            graph_base_q  <= graph_base_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            start_pulse_q <= start_pulse_d;
            irq_q         <= irq_d;
            irq_en_q      <= irq_en_d;
            done_q        <= done_d;
            lock_err_q    <= lock_err_d;
            collide_q     <= collide_d;
            commit_pend_q <= commit_pend_d;
        end
    end

    assign rd_data            = rd_data_q;
    assign rd_valid           = rd_valid_q;
    assign start_pulse        = start_pulse_q;
    assign irq                = irq_q;
    assign start_node_address = start_node_q;
    assign graph_base_address = graph_base_q;
    assign high_thr           = act_hi;
    assign med_thr            = act_med;
endmodule

// File: tb/tb_bfs_config_regfile.sv
// Bench for bfs_config_regfile: directed scenarios plus a randomized run
// against a register-map level reference model.

module tb_bfs_config_regfile;
    localparam int NCH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, wr_en, rd_en, engine_busy, engine_done, rd_valid, start_pulse, irq;
    logic [11:0] wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data, start_node_address, graph_base_address;
    logic [NCH-1:0] lse_we;
    logic [NCH*32-1:0] lse_high_in, lse_med_in, high_thr, med_thr;

    bfs_config_regfile dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .engine_busy(engine_busy), .engine_done(engine_done), .lse_we(lse_we),
        .lse_high_in(lse_high_in), .lse_med_in(lse_med_in),
        .start_node_address(start_node_address), .graph_base_address(graph_base_address),
        .high_thr(high_thr), .med_thr(med_thr), .start_pulse(start_pulse), .irq(irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: register map as plain variables
    logic [31:0] m_sn, m_gb, m_rd;
    logic [31:0] m_sh_hi[NCH], m_sh_med[NCH], m_act_hi[NCH], m_act_med[NCH];
    bit m_irq_en, m_done, m_lock, m_coll, m_pend, m_start, m_irq, m_rv;

    function automatic logic [31:0] mread(logic [11:0] a);
        int unsigned w = int'(a) & 32'hFFC;
        if (w == 0)  return 32'hBF50_0002;
        if (w == 4)  return m_sn;
        if (w == 8)  return m_gb;
        if (w == 12) return {30'd0, m_irq_en, 1'b0};
        if (w == 16) return {27'd0, m_pend, m_coll, m_lock, m_done, engine_busy};
        if (w >= 32 && w < 32 + 8*NCH) return (w % 8 == 0) ? m_sh_hi[(w-32)/8] : m_sh_med[(w-32)/8];
        return 32'd0;
    endfunction

    task automatic model_step();
        logic [31:0] old_hi[NCH], old_med[NCH];
        int unsigned w;
        bit lock, coll;
        if (rst) begin
            m_sn = 0; m_gb = 0; m_rd = 0;
            m_irq_en = 0; m_done = 0; m_lock = 0; m_coll = 0; m_pend = 0;
            m_start = 0; m_irq = 0; m_rv = 0;
            for (int i = 0; i < NCH; i++) begin
                m_sh_hi[i] = 0; m_sh_med[i] = 0; m_act_hi[i] = 0; m_act_med[i] = 0;
            end
            return;
        end
        m_rv = rd_en;
        if (rd_en) m_rd = mread(rd_addr);
        old_hi = m_sh_hi; old_med = m_sh_med;
        lock = 0; coll = 0; m_start = 0;
        if (m_pend && !engine_busy) begin
            m_act_hi = old_hi; m_act_med = old_med; m_pend = 0;
        end
        if (wr_en) begin
            w = int'(wr_addr) & 32'hFFC;
            if (w == 4)       begin if (engine_busy) lock = 1; else m_sn = wr_data; end
            else if (w == 8)  begin if (engine_busy) lock = 1; else m_gb = wr_data; end
            else if (w == 12) begin
                if (engine_busy && wr_data[0]) lock = 1;
                else begin
                    m_irq_en = wr_data[1];
                    m_start  = wr_data[0];
                    if (wr_data[2]) m_pend = 1;
                end
            end
            else if (w == 16) begin
                if (wr_data[1]) m_done = 0;
                if (wr_data[2]) m_lock = 0;
                if (wr_data[3]) m_coll = 0;
            end
            else if (w >= 32 && w < 32 + 8*NCH) begin
                if (lse_we[(w-32)/8]) coll = 1;
                else if (w % 8 == 0) m_sh_hi[(w-32)/8] = wr_data;
                else m_sh_med[(w-32)/8] = wr_data;
            end
        end
        m_done = m_done | engine_done;
        m_lock = m_lock | lock;
        m_coll = m_coll | coll;
        for (int i = 0; i < NCH; i++) if (lse_we[i]) begin
            m_sh_hi[i]  = lse_high_in[i*32 +: 32]; m_act_hi[i]  = lse_high_in[i*32 +: 32];
            m_sh_med[i] = lse_med_in[i*32 +: 32];  m_act_med[i] = lse_med_in[i*32 +: 32];
        end
        m_irq = m_irq_en & (m_done | m_lock | m_coll);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic v);
        rd_en = 1; rd_addr = a;
        tick();
        rd_en = 0;
        d = rd_data; v = rd_valid;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        rst = 1; tick(); tick(); rst = 0;
        n_tests++; if ({rd_valid, start_pulse, irq} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {rd_valid, start_pulse, irq}); end
        n_tests++; if ({start_node_address, graph_base_address, rd_data} !== 96'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", {start_node_address, graph_base_address, rd_data}); end
        n_tests++; if ({high_thr, med_thr} !== 256'd0) begin n_fail++; $display("FAIL reset_thr got %h want 0", {high_thr, med_thr}); end
        rd(12'h000, d, v);
        n_tests++; if (v !== 1'b1 || d !== 32'hBF50_0002) begin n_fail++; $display("FAIL read_id got v=%b d=%h want v=1 d=bf500002", v, d); end
        rd(12'h020, d, v);
        n_tests++; if (v !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL read_sh0 got v=%b d=%h want v=1 d=0", v, d); end
        tick();
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_drop got %b want 0", rd_valid); end
    endtask

    task automatic test_commit_idle();
        engine_busy = 0;
        wr(12'h020, 100); wr(12'h024, 50);
        wr(12'h00C, 4);
        n_tests++; if (high_thr[31:0] !== 32'd0) begin n_fail++; $display("FAIL commit_early got %0d want 0", high_thr[31:0]); end
        tick();
        n_tests++; if (high_thr[31:0] !== 32'd100 || med_thr[31:0] !== 32'd50) begin n_fail++; $display("FAIL commit_idle got %0d/%0d want 100/50", high_thr[31:0], med_thr[31:0]); end
    endtask

    task automatic test_commit_busy();
        logic [31:0] d; logic v;
        engine_busy = 1;
        wr(12'h028, 7); wr(12'h00C, 4);
        rd(12'h010, d, v);
        n_tests++; if (d !== 32'h11) begin n_fail++; $display("FAIL status_pend got %h want 11", d); end
        n_tests++; if (high_thr[63:32] !== 32'd0) begin n_fail++; $display("FAIL commit_deferred got %0d want 0", high_thr[63:32]); end
        engine_busy = 0;
        tick();
        n_tests++; if (high_thr[63:32] !== 32'd7) begin n_fail++; $display("FAIL commit_release got %0d want 7", high_thr[63:32]); end
        rd(12'h010, d, v);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL pend_clear got %h want 0", d); end
    endtask

    task automatic test_lockout();
        logic [31:0] d; logic v;
        engine_busy = 1;
        wr(12'h00C, 3);
        n_tests++; if (start_pulse !== 1'b0) begin n_fail++; $display("FAIL lock_nostart got %b want 0", start_pulse); end
        wr(12'h004, 32'h55);
        n_tests++; if (start_node_address !== 32'd0) begin n_fail++; $display("FAIL lock_sn got %h want 0", start_node_address); end
        rd(12'h00C, d, v);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL lock_irqen got %h want 0", d); end
        rd(12'h010, d, v);
        n_tests++; if (d !== 32'h5) begin n_fail++; $display("FAIL lock_err got %h want 5", d); end
        engine_busy = 0;
        wr(12'h00C, 3);
        n_tests++; if (start_pulse !== 1'b1 || irq !== 1'b1) begin n_fail++; $display("FAIL start_irq got sp=%b irq=%b want 1/1", start_pulse, irq); end
        tick();
        n_tests++; if (start_pulse !== 1'b0) begin n_fail++; $display("FAIL start_once got %b want 0", start_pulse); end
        engine_done = 1; tick(); engine_done = 0;
        rd(12'h010, d, v);
        n_tests++; if (d !== 32'h6 || irq !== 1'b1) begin n_fail++; $display("FAIL done_set got %h irq=%b want 6 irq=1", d, irq); end
        wr(12'h010, 6);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq got %b want 0", irq); end
    endtask

    task automatic test_collide();
        logic [31:0] d; logic v;
        lse_we = 4'b0100;
        lse_high_in[95:64] = 900; lse_med_in[95:64] = 300;
        wr(12'h030, 5);
        lse_we = '0;
        n_tests++; if (high_thr[95:64] !== 32'd900 || med_thr[95:64] !== 32'd300) begin n_fail++; $display("FAIL lse_active got %0d/%0d want 900/300", high_thr[95:64], med_thr[95:64]); end
        rd(12'h030, d, v);
        n_tests++; if (d !== 32'd900) begin n_fail++; $display("FAIL lse_shadow got %0d want 900", d); end
        rd(12'h034, d, v);
        n_tests++; if (d !== 32'd300) begin n_fail++; $display("FAIL lse_shadow_med got %0d want 300", d); end
        rd(12'h010, d, v);
        n_tests++; if (d !== 32'h8 || irq !== 1'b1) begin n_fail++; $display("FAIL collide got %h irq=%b want 8 irq=1", d, irq); end
        wr(12'h010, 8);
    endtask

    task automatic test_done_race();
        logic [31:0] d; logic v;
        engine_done = 1;
        wr(12'h010, 2);
        engine_done = 0;
        rd(12'h010, d, v);
        n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL set_wins got %h want 2", d); end
        wr(12'h010, 2);
        rd(12'h010, d, v);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_done got %h want 0", d); end
    endtask

    task automatic test_back_to_back();
        wr_en = 1; wr_addr = 12'h00C; wr_data = 1;
        tick();
        n_tests++; if (start_pulse !== 1'b1) begin n_fail++; $display("FAIL b2b_first got %b want 1", start_pulse); end
        tick();
        wr_en = 0;
        n_tests++; if (start_pulse !== 1'b1) begin n_fail++; $display("FAIL b2b_second got %b want 1", start_pulse); end
        tick();
        n_tests++; if (start_pulse !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", start_pulse); end
    endtask

    task automatic test_mid_reset();
        engine_busy = 0;
        wr(12'h00C, 4);
        rd_en = 1; rd_addr = 12'h000; rst = 1;
        tick();
        rst = 0; rd_en = 0;
        n_tests++; if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin n_fail++; $display("FAIL mid_reset_rd got v=%b d=%h want 0/0", rd_valid, rd_data); end
        tick();
        n_tests++; if (high_thr !== '0) begin n_fail++; $display("FAIL mid_reset_commit got %h want 0", high_thr); end
    endtask

    task automatic test_random();
        int addrs[16] = '{0, 4, 8, 12, 16, 32, 36, 40, 44, 48, 52, 56, 60, 64, 256, 4092};
        int bad = 0;
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 1500; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            wr_en       = ($urandom_range(0, 1) == 1);
            wr_addr     = 12'(addrs[$urandom_range(0, 15)] | $urandom_range(0, 3));
            wr_data     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
            rd_en       = ($urandom_range(0, 1) == 1);
            rd_addr     = 12'(addrs[$urandom_range(0, 15)] | $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) engine_busy = ~engine_busy;
            engine_done = ($urandom_range(0, 9) == 0);
            lse_we      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            lse_high_in = {$urandom, $urandom, $urandom, $urandom};
            lse_med_in  = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n_tests++;
            if (rd_valid !== m_rv || (m_rv && rd_data !== m_rd) || start_pulse !== m_start || irq !== m_irq ||
                start_node_address !== m_sn || graph_base_address !== m_gb) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand_ctl cyc %0d got rv=%b rd=%h sp=%b irq=%b sn=%h gb=%h want rv=%b rd=%h sp=%b irq=%b sn=%h gb=%h",
                    c, rd_valid, rd_data, start_pulse, irq, start_node_address, graph_base_address, m_rv, m_rd, m_start, m_irq, m_sn, m_gb);
            end
            for (int i = 0; i < NCH; i++) begin
                n_tests++;
                if (high_thr[i*32 +: 32] !== m_act_hi[i] || med_thr[i*32 +: 32] !== m_act_med[i]) begin
                    n_fail++; bad++;
                    if (bad < 10) $display("FAIL rand_thr cyc %0d ch %0d got %h/%h want %h/%h",
                        c, i, high_thr[i*32 +: 32], med_thr[i*32 +: 32], m_act_hi[i], m_act_med[i]);
                end
            end
        end
        rst = 0; wr_en = 0; rd_en = 0; engine_done = 0; lse_we = '0;
    endtask

    initial begin
        rst = 1; wr_en = 0; rd_en = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        engine_busy = 0; engine_done = 0; lse_we = '0; lse_high_in = '0; lse_med_in = '0;
        test_reset();
        test_commit_idle();
        test_commit_busy();
        test_lockout();
        test_collide();
        test_done_race();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bfs_config_regfile.md
Name: bfs_config_regfile

Overview:
- Parametrised successor to the single-set BFS configuration register block.
- Holds the per-channel degree-threshold pairs in shadow and active copies, with atomic commit deferred while the engine is busy.
- Generates a one-cycle start pulse, write-1-to-clear (W1C) status flags and an interrupt.
- Sits between the AXI-Lite slave decode and the BFS engine / lookahead engine (LSE).

Parameters:
- ADDR_WIDTH, 12, bus byte-address width
- DATA_WIDTH, 32, register width (min 8)
- NUM_CH, 4, threshold channel count, legal 1..16
- ID_VALUE, 32'hBF50_0002, read-only ID register contents (truncated to DATA_WIDTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  bus write strobe
- wr_addr  in  ADDR_WIDTH  write byte address
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  bus read strobe
- rd_addr  in  ADDR_WIDTH  read byte address
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  rd_data valid, exactly 1 cycle after rd_en
- engine_busy  in  1  BFS engine running
- engine_done  in  1  single-cycle completion pulse
- lse_we  in  NUM_CH  per-channel LSE threshold write enable
- lse_high_in  in  NUM_CH*DATA_WIDTH  LSE high thresholds, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- lse_med_in  in  NUM_CH*DATA_WIDTH  LSE medium thresholds, same packing
- start_node_address  out  DATA_WIDTH  configuration
- graph_base_address  out  DATA_WIDTH  configuration
- high_thr  out  NUM_CH*DATA_WIDTH  active high thresholds
- med_thr  out  NUM_CH*DATA_WIDTH  active medium thresholds
- start_pulse  out  1  one-cycle engine start
- irq  out  1  level interrupt

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous, active-high. On rst every register and output is 0 (rd_data, rd_valid, start_pulse, irq, all addresses, all shadow and active thresholds, all flags). commit_pending clears.
- Address map (byte addresses, word-aligned; wr_addr/rd_addr[1:0] are ignored):
  - 0x000 ID: read-only.
  - 0x004 START_NODE.
  - 0x008 GRAPH_BASE.
  - 0x00C CONTROL:
    - bit0 START: write-only, reads 0.
    - bit1 IRQ_EN: read/write.
    - bit2 COMMIT: write-only, reads 0.
  - 0x010 STATUS:
    - bit0 BUSY: read-only, mirrors engine_busy.
    - bit1 DONE: W1C.
    - bit2 LOCK_ERR: W1C.
    - bit3 COLLIDE: W1C.
    - bit4 COMMIT_PEND: read-only.
  - 0x020+8*i: HIGH shadow, channel i.
  - 0x024+8*i: MED shadow, channel i, for i < NUM_CH.
  - Unmapped writes are ignored; unmapped reads return 0.
- Read path: rd_data and rd_valid are registered; rd_valid = rd_en delayed by 1 cycle. A read returns register state from before any same-cycle write.
- Busy lockout: a write to START_NODE, GRAPH_BASE, or CONTROL with START=1 while engine_busy=1 is dropped entirely (IRQ_EN and COMMIT in that write are also dropped) and sets LOCK_ERR.
- Start: a CONTROL write with bit0=1 while engine_busy=0 drives start_pulse=1 on the following cycle only. Back-to-back start writes give back-to-back pulses.
- Shadow threshold writes are always accepted.
- Commit: a CONTROL write with bit2=1 sets commit_pending.
  - When commit_pending=1 and engine_busy=0, all active thresholds load from shadow at that clock edge and commit_pending clears.
  - A commit written while idle therefore takes effect 1 cycle after the write edge.
  - A commit written while busy is deferred until engine_busy falls.
- LSE write: lse_we[i] loads both shadow and active copies of channel i in the same edge. This overrides any commit for channel i in that cycle.
- Collision: a bus write to a shadow register of channel i in the same cycle as lse_we[i] is dropped and sets COLLIDE.
- DONE: engine_done sets DONE. If a W1C of a bit and a hardware set of the same bit occur in the same cycle, the set wins.
- Interrupt: irq (registered) = IRQ_EN & (DONE | LOCK_ERR | COLLIDE).
- Mid-operation reset: rst has priority over all events; pending commits and in-flight reads are discarded (rd_valid=0 on the cycle after rst).

Test Plan:
- Reset, then read 0x000 and 0x020 -> rd_valid 1 cycle later; data 0xBF500002, then 0. All outputs 0.
- engine_busy=0; write 0x020=100, 0x024=50, then CONTROL=0x4 -> high_thr[ch0]=100, med_thr[ch0]=50 one cycle after the CONTROL write. high_thr is unchanged before the commit.
- engine_busy=1; write 0x028=7, CONTROL=0x4 -> STATUS reads 0x11, high_thr[ch1] unchanged. Drop engine_busy -> high_thr[ch1]=7 next edge, COMMIT_PEND clears.
- engine_busy=1; write CONTROL=0x3 -> no start_pulse, IRQ_EN stays 0, LOCK_ERR=1. Then busy=0, CONTROL=0x3 -> one start_pulse. engine_done pulse -> DONE=1, irq=1. Write STATUS=0x6 -> irq=0.
- lse_we[2]=1 with high 900 / med 300, same cycle as a bus write 0x030=5 -> channel-2 shadow and active = 900/300, COLLIDE=1, 0x030 reads 900.
- engine_done in the same cycle as STATUS write 0x2 -> DONE remains 1.
